// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT byte FIFO with
// fill level, sticky overflow and a count of buffered end-of-line bytes.
module uart_rx_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  EOL_BYTE   = 8'h0A
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Done_i,
    input  logic [7:0]            Data_i,
    input  logic                  Read_i,
    input  logic                  ClearOverflow_i,
    output logic [7:0]            Data_o,
    output logic                  Valid_o,
    output logic                  Full_o,
    output logic [DEPTH_LOG2:0]   Count_o,
    output logic                  Overflow_o,
    output logic [DEPTH_LOG2:0]   Lines_o,
    output logic                  LineReady_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   lines;
    logic                  overflow;

    logic       pop;
    logic       push;
    logic       drop;
    logic [7:0] head;

    assign head = mem[rd_ptr];
    assign pop  = Read_i && (count != '0);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push = Done_i && ((count != CNT_FULL) || pop);
    assign drop = Done_i && !push;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= Data_i;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            lines    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            unique case ({push && (Data_i == EOL_BYTE),
                          pop && (head == EOL_BYTE)})
                2'b10:   lines <= lines + CNT_ONE;
                2'b01:   lines <= lines - CNT_ONE;
                default: lines <= lines;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (ClearOverflow_i) begin
                overflow <= 1'b0;
            end
        end
    end

    assign Valid_o     = (count != '0);
    assign Full_o      = (count == CNT_FULL);
    assign Count_o     = count;
    assign Data_o      = Valid_o ? head : 8'h00;
    assign Overflow_o  = overflow;
    assign Lines_o     = lines;
    assign LineReady_o = (lines != '0);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Captures each byte the receiver presents with its one-cycle Done strobe into a first-word-fall-through FIFO. Gives the consumer (command parser, bus bridge) a valid/read handshake, fill level, sticky overflow flag and a count of complete lines (bytes equal to EOL_BYTE) currently buffered.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 bytes (16 by default); legal range 2..8
EOL_BYTE, 8'h0A, byte value counted as end of line

Ports:
Clock  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Done_i  input  1  one-cycle strobe from UART receiver: Data_i valid this cycle
Data_i  input  8  received byte, sampled only when Done_i=1
Read_i  input  1  consumer pop request; acts only when Valid_o=1
ClearOverflow_i  input  1  clears Overflow_o
Data_o  output  8  head byte (FWFT); 8'h00 whenever Valid_o=0
Valid_o  output  1  FIFO not empty
Full_o  output  1  FIFO holds 2**DEPTH_LOG2 bytes
Count_o  output  DEPTH_LOG2+1  number of bytes stored
Overflow_o  output  1  sticky: a byte was dropped because FIFO was full
Lines_o  output  DEPTH_LOG2+1  number of EOL_BYTE entries currently stored
LineReady_o  output  1  Lines_o != 0

Behaviour:
- Reset (sampled on Clock edge while Reset=1): read/write pointers 0, Count_o 0, Valid_o 0, Full_o 0, Data_o 8'h00, Overflow_o 0, Lines_o 0, LineReady_o 0. Reset wins over all other inputs; a reset mid-stream discards all buffered data; memory contents need not be cleared.
- Storage: 2**DEPTH_LOG2 x 8 array; pointers DEPTH_LOG2 bits, wrap naturally modulo depth; Count_o tracked explicitly (no pointer-compare ambiguity).
- All outputs registered or derived only from registered state; no combinational path from any input to any output.
- Write: on edge where Done_i=1 and (Full_o=0 or pop occurs same edge) -> Data_i stored at write pointer, write pointer +1.
- Pop: on edge where Read_i=1 and Valid_o=1 -> read pointer +1. Read_i while Valid_o=0 ignored (no underflow, no state change).
- Write-to-read latency: byte written at edge N appears on Data_o with Valid_o=1 after edge N (usable cycle N+1) if FIFO was empty.
- Data_o always equals entry at read pointer while Valid_o=1; after a pop it shows next entry from the following cycle.
- Count: write only +1; pop only -1; both unchanged. Full_o = (Count_o == depth); Valid_o = (Count_o != 0).
- Simultaneous write+pop when full: both performed, Count_o stays at depth, no overflow.
- Simultaneous Done_i and Read_i when empty: write performed, read ignored, Count_o becomes 1.
- Overflow: Done_i=1, Full_o=1, no pop same edge -> byte dropped, contents untouched, Overflow_o=1 from next cycle, held until ClearOverflow_i. Set and clear same edge -> set wins.
- Lines_o: +1 when a stored (not dropped) byte equals EOL_BYTE; -1 when popped head equals EOL_BYTE; both same edge -> unchanged. Never exceeds Count_o.
- Done_i pulses may arrive every cycle; no minimum spacing required.

Test Plan:
- Reset, then Done_i with 8'h41, 8'h42, 8'h43 on consecutive cycles -> Valid_o=1 cycle after first write, Data_o=8'h41, Count_o=3; three Read_i pops yield 41,42,43, then Valid_o=0, Data_o=8'h00.
- Write 16 bytes 8'h00..8'h0F (DEPTH_LOG2=4) -> Full_o=1, Count_o=16; 17th Done_i with 8'hFF -> Overflow_o=1 next cycle, Count_o=16, pops return 00..0F only; ClearOverflow_i -> Overflow_o=0.
- Full FIFO, Done_i=8'hAA with Read_i same cycle -> Overflow_o stays 0, Count_o=16, Data_o advances to 8'h01, 8'hAA is last byte popped.
- Empty FIFO, Done_i=8'h55 with Read_i same cycle -> Count_o=1, Data_o=8'h55 next cycle.
- Write "AB\nC\n" (41,42,0A,43,0A) -> Lines_o=2, LineReady_o=1; pop 3 bytes -> Lines_o=1; pop 2 more -> Lines_o=0, LineReady_o=0; overflowed 8'h0A while full -> Lines_o unchanged.
- Pointer wrap: 40 write/pop pairs of incrementing bytes at 1-3 bytes fill level -> output order preserved; Reset asserted with Count_o=5 -> next cycle Count_o=0, Valid_o=0, Lines_o=0, Overflow_o=0.
